// File: rtl/lane_collision_if.sv
// Lane collision bus: car-lane occupancy and frog position in, hit/status/display row out.
interface lane_collision_if;
    logic [15:0] car_pixels;
    logic [3:0]  frog_col;
    logic        frog_on_row;
    logic        restart;
    logic        hit;
    logic        game_over;
    logic [1:0]  lives;
    logic [15:0] row_pixels;

    modport master (
        output car_pixels, frog_col, frog_on_row, restart,
        input  hit, game_over, lives, row_pixels
    );

    modport slave (
        input  car_pixels, frog_col, frog_on_row, restart,
        output hit, game_over, lives, row_pixels
    );
endinterface

// File: rtl/lane_collision.sv
// Frog-versus-car collision tracker for one lane: lives, invulnerability window,
// game-over latch and the merged display row with a blinking frog during recovery.
module lane_collision #(
    parameter int LIVES          = 3,
    parameter int RECOVER_CYCLES = 512,
    parameter int BLINK_BIT      = 5
) (
    input  logic             clk,
    input  logic             reset,
    lane_collision_if.slave  bus
);
    localparam int CW = 16;
    localparam logic [1:0]    LIVES_INIT   = 2'(LIVES);
    localparam logic [CW-1:0] RECOVER_LOAD = CW'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_HIT     = 2'd1,
        ST_RECOVER = 2'd2,
        ST_DEAD    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d;
    logic          game_over_q, game_over_d;

    logic          collision_s;
    logic          show_frog_s;
    logic [15:0]   frog_mask_s;

    assign collision_s = bus.frog_on_row & bus.car_pixels[bus.frog_col];

    // Next-state, lives and recovery-counter logic; outputs decoded from the next state.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_PLAY: begin
                if (collision_s) begin
                    state_d = ST_HIT;
                    lives_d = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_HIT: begin
                if (lives_q == 2'd0) begin
                    state_d = ST_DEAD;
                end else begin
                    state_d = ST_RECOVER;
                    cnt_d   = RECOVER_LOAD;
                end
            end
            ST_RECOVER: begin
                // A collision on the final recovery cycle is deliberately not seen.
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_DEAD: begin
                if (bus.restart) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_INIT;
                end else begin
                    state_d = ST_DEAD;
                end
            end
            default: begin
                state_d = ST_PLAY;
                lives_d = LIVES_INIT;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        hit_d       = (state_d == ST_HIT);
        game_over_d = (state_d == ST_DEAD);
    end

    // State and registered status outputs, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PLAY;
            lives_q     <= LIVES_INIT;
            cnt_q       <= {CW{1'b0}};
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            game_over_q <= game_over_d;
        end
    end

    assign frog_mask_s = 16'd1 << bus.frog_col;

    // Frog marker visibility: solid in PLAY/HIT, blinking in RECOVER, removed in DEAD.
    always_comb begin
        show_frog_s = 1'b0;
        case (state_q)
            ST_PLAY:    show_frog_s = bus.frog_on_row;
            ST_HIT:     show_frog_s = bus.frog_on_row;
            ST_RECOVER: show_frog_s = bus.frog_on_row & cnt_q[BLINK_BIT];
            ST_DEAD:    show_frog_s = 1'b0;
            default:    show_frog_s = 1'b0;
        endcase
    end

    assign bus.row_pixels = show_frog_s ? (bus.car_pixels | frog_mask_s) : bus.car_pixels;
    assign bus.hit        = hit_q;
    assign bus.game_over  = game_over_q;
    assign bus.lives      = lives_q;
endmodule

// File: tb/tb_lane_collision.sv
// Scoreboard bench for lane_collision: the driver pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_lane_collision;
    logic clk;
    logic reset;
    lane_collision_if bus();

    lane_collision #(.LIVES(3), .RECOVER_CYCLES(512), .BLINK_BIT(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic        go;
        logic [1:0]  lives;
        logic [15:0] row;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hit_seen = 0;
    int last_hit = 0;
    int prev_hit = 0;

    // reference model: 0 play, 1 hit, 2 recover, 3 dead
    int          m_st;
    int          m_lives;
    logic [15:0] m_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_lives = 3;
        m_cnt   = 16'd0;
    endtask

    task automatic model_step();
        logic coll;
        coll = bus.frog_on_row & bus.car_pixels[bus.frog_col];
        case (m_st)
            0: if (coll) begin
                   m_st    = 1;
                   m_lives = (m_lives > 0) ? m_lives - 1 : 0;
               end
            1: if (m_lives == 0) m_st = 3;
               else begin
                   m_st  = 2;
                   m_cnt = 16'd511;
               end
            2: if (m_cnt == 16'd0) m_st = 0;
               else m_cnt = m_cnt - 16'd1;
            3: if (bus.restart) begin
                   m_st    = 0;
                   m_lives = 3;
               end
            default: m_st = 0;
        endcase
    endtask

    function automatic logic [15:0] model_row(input logic [15:0] car, input logic [3:0] col,
                                              input logic on);
        logic [15:0] r;
        r = car;
        if (on && (m_st == 0 || m_st == 1 || (m_st == 2 && m_cnt[5] == 1'b1)))
            r[col] = 1'b1;
        return r;
    endfunction

    // One clock: model sees inputs sampled at the edge, then new inputs go on and
    // the expectation for the following negedge is queued.
    task automatic tick(input logic [15:0] car, input logic [3:0] col, input logic on,
                        input logic rs);
        exp_t e;
        @(posedge clk);
        model_step();
        #1;
        bus.car_pixels  = car;
        bus.frog_col    = col;
        bus.frog_on_row = on;
        bus.restart     = rs;
        e.hit   = (m_st == 1);
        e.go    = (m_st == 3);
        e.lives = 2'(m_lives);
        e.row   = model_row(car, col, on);
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            tick(bus.car_pixels, bus.frog_col, bus.frog_on_row, bus.restart);
    endtask

    // Monitor: compares every queued expectation at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.hit === 1'b1) begin
            hit_seen++;
            prev_hit = last_hit;
            last_hit = cyc;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hit", {31'd0, bus.hit}, {31'd0, e.hit});
            check("game_over", {31'd0, bus.game_over}, {31'd0, e.go});
            check("lives", {30'd0, bus.lives}, {30'd0, e.lives});
            check("row_pixels", {16'd0, bus.row_pixels}, {16'd0, e.row});
        end
    end

    initial begin
        reset           = 1'b1;
        bus.car_pixels  = 16'hCCCC;
        bus.frog_col    = 4'd0;
        bus.frog_on_row = 1'b0;
        bus.restart     = 1'b0;
        model_reset();
        #3;
        check("rst_hit", {31'd0, bus.hit}, 32'd0);
        check("rst_go", {31'd0, bus.game_over}, 32'd0);
        check("rst_lives", {30'd0, bus.lives}, 32'd3);
        @(negedge clk);
        #1 reset = 1'b0;

        // pass-through row, frog off-row, then frog on an empty lane
        run(3);
        tick(16'h0000, 4'd1, 1'b1, 1'b0);
        run(3);
        @(negedge clk); #1;
        check("frog_marker_row", {16'd0, bus.row_pixels}, 32'h0002);

        // held collision: hit, 512-cycle recovery, re-hit on first PLAY cycle
        tick(16'h0010, 4'd4, 1'b1, 1'b0);
        run(720);
        @(negedge clk); #1;
        check("lives_after_two_hits", {30'd0, bus.lives}, 32'd1);
        check("hit_count_two", hit_seen, 32'd2);
        check("hit_gap", last_hit - prev_hit, 32'd514);

        // asynchronous reset mid-recovery, between clock edges
        reset = 1'b1;
        #1;
        check("async_rst_lives", {30'd0, bus.lives}, 32'd3);
        check("async_rst_hit", {31'd0, bus.hit}, 32'd0);
        check("async_rst_go", {31'd0, bus.game_over}, 32'd0);
        check("async_rst_row", {16'd0, bus.row_pixels}, 32'h0010);
        model_reset();
        @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;

        // three hits to DEAD, then collisions produce nothing
        run(3 * 514 + 60);
        @(negedge clk); #1;
        check("dead_go", {31'd0, bus.game_over}, 32'd1);
        check("dead_lives", {30'd0, bus.lives}, 32'd0);
        check("hit_count_five", hit_seen, 32'd5);
        check("dead_row", {16'd0, bus.row_pixels}, 32'h0010);

        // restart out of DEAD, then a restart pulse in PLAY does nothing
        tick(16'h0010, 4'd4, 1'b0, 1'b0);
        run(2);
        tick(16'h0010, 4'd4, 1'b0, 1'b1);
        tick(16'h0010, 4'd4, 1'b0, 1'b0);
        run(3);
        @(negedge clk); #1;
        check("restart_lives", {30'd0, bus.lives}, 32'd3);
        check("restart_go", {31'd0, bus.game_over}, 32'd0);
        tick(16'h0010, 4'd4, 1'b0, 1'b1);
        tick(16'h0010, 4'd4, 1'b0, 1'b0);
        run(3);
        @(negedge clk); #1;
        check("play_restart_lives", {30'd0, bus.lives}, 32'd3);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lane_collision.md
LANE_COLLISION -- requirements
Module: lane_collision

Interface
REQ-001 SHALL have parameter LIVES, default 3, number of lives loaded at reset and restart (legal range 1..3).
REQ-002 SHALL have parameter RECOVER_CYCLES, default 512, invulnerability window length in clock cycles (legal range 2..65535).
REQ-003 SHALL have parameter BLINK_BIT, default 5, the recovery-counter bit that gates frog blinking (must be below counter width).
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port car_pixels  input  16  lane occupancy from the upstream car-lane block; bit i = column i.
REQ-007 SHALL have port frog_col  input  4  frog column; value n selects car_pixels[n].
REQ-008 SHALL have port frog_on_row  input  1  frog currently occupies this lane.
REQ-009 SHALL have port restart  input  1  synchronous request to start a new game; honoured only in DEAD.
REQ-010 SHALL have port hit  output  1  registered single-cycle collision pulse, fed back to the car-lane block.
REQ-011 SHALL have port game_over  output  1  registered level, high in DEAD.
REQ-012 SHALL have port lives  output  2  remaining lives.
REQ-013 SHALL have port row_pixels  output  16  display row: car pixels merged with frog marker.

Function
REQ-014 SHALL implement states PLAY, HIT, RECOVER, DEAD.
REQ-015 SHALL define collision as frog_on_row AND car_pixels[frog_col], sampled combinationally each cycle.
REQ-016 PLAY: collision -> HIT, with lives decremented by 1 on the same edge; otherwise stay in PLAY.
REQ-017 HIT: lasts exactly one cycle; hit = 1 only in this state.
REQ-018 HIT: lives == 0 -> DEAD; otherwise -> RECOVER, with the recovery counter loaded to RECOVER_CYCLES-1.
REQ-019 RECOVER: counter decrements by 1 per cycle; collisions ignored; at count 0 -> PLAY on the next edge (RECOVER_CYCLES cycles in RECOVER total).
REQ-020 DEAD: terminal; collisions ignored; restart = 1 -> PLAY, with lives reloaded to LIVES.
REQ-021 restart SHALL be ignored in PLAY, HIT and RECOVER.
REQ-022 lives SHALL saturate at 0 and never wrap.
REQ-023 hit and game_over SHALL be state-decoded registered outputs, with no combinational path from inputs.
REQ-024 row_pixels in PLAY and HIT: car_pixels with bit frog_col forced to 1 when frog_on_row.
REQ-025 row_pixels in RECOVER: same as PLAY, but the frog bit is forced only when counter[BLINK_BIT] = 1.
REQ-026 row_pixels in DEAD: car_pixels unchanged (frog removed).
REQ-027 row_pixels SHALL be combinational from the current state, counter and inputs.
REQ-028 A collision arriving in the same cycle as the RECOVER->PLAY transition SHALL be ignored; it is detected from the first PLAY cycle onward.

Reset
REQ-029 reset asserted SHALL immediately and asynchronously force: state PLAY, lives = LIVES, counter 0, hit 0, game_over 0.
REQ-030 reset asserted mid-RECOVER or in DEAD SHALL discard all progress with no residual hit pulse.
REQ-031 After reset deasserts, the first evaluated edge SHALL behave as PLAY.

Verification
REQ-032 Defaults; frog_on_row=1, frog_col=4, car_pixels=16'h0010 held -> hit pulses exactly 1 cycle; lives 3->2; then RECOVER for exactly 512 cycles with no further hit; re-hit on first PLAY cycle (lives 1).
REQ-033 Three collisions separated by recovery -> lives 3,2,1,0; third HIT -> DEAD; game_over=1; further collisions produce no hit.
REQ-034 In DEAD, restart=1 for 1 cycle -> PLAY; lives=3; game_over=0; restart pulsed in PLAY -> no change.
REQ-035 car_pixels=16'hCCCC, frog_col=0, frog_on_row=0 -> row_pixels=16'hCCCC, no hit; frog_on_row=1, frog_col=1, car_pixels=16'h0000 -> row_pixels=16'h0002, no hit.
REQ-036 During RECOVER, row_pixels frog bit toggles every 32 cycles (BLINK_BIT=5); car bits pass through unchanged.
REQ-037 Assert reset asynchronously (between clock edges) mid-RECOVER -> outputs return to reset values before the next edge; lives=3.
